// File: rtl/spi_slave_rx.sv
// SPI receive endpoint: oversamples sclk/cs/mosi on clk, shifts DATA_W bits LSB first,
// and presents each word on a valid/ready port with frame-error and overrun pulses.
module spi_slave_rx #(
    parameter int DATA_W     = 12,
    parameter int LEAD_EDGES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LEAD = CNT_W'(LEAD_EDGES);

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        SHIFT,
        WAIT_CS
    } state_t;

    state_t state, state_next;

    logic sclk_p0, sclk_p1, sclk_p2;
    logic cs_p0, cs_p1, cs_p2;
    logic mosi_p0, mosi_p1;
    logic [1:0] warm_cnt;
    logic warm;
    logic sclk_fall, cs_fall, cs_rise;

    logic [CNT_W-1:0]  count, count_next;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] word;
    logic shift_en, load, frame_err_next;

    // Stage p0/p1: two-flop synchronizers; p2: history flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_p0  <= 1'b0;
            sclk_p1  <= 1'b0;
            sclk_p2  <= 1'b0;
            cs_p0    <= 1'b1;
            cs_p1    <= 1'b1;
            cs_p2    <= 1'b1;
            mosi_p0  <= 1'b0;
            mosi_p1  <= 1'b0;
            warm_cnt <= 2'd0;
        end else begin
            sclk_p0 <= sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            cs_p0   <= cs;
            cs_p1   <= cs_p0;
            cs_p2   <= cs_p1;
            mosi_p0 <= mosi;
            mosi_p1 <= mosi_p0;
            if (!warm)
                warm_cnt <= warm_cnt + 2'd1;
        end
    end

    // Reset values in the synchronizer are not real observations of the pins; until they
    // have flushed, a cs held low through reset would look like a fresh falling edge.
    assign warm      = (warm_cnt == 2'd3);
    assign sclk_fall = sclk_p2 & ~sclk_p1;
    assign cs_fall   = cs_p2 & ~cs_p1;
    assign cs_rise   = ~cs_p2 & cs_p1;

    always_comb begin
        state_next     = state;
        count_next     = count;
        shift_en       = 1'b0;
        load           = 1'b0;
        frame_err_next = 1'b0;
        case (state)
            IDLE: begin
                if (warm) begin
                    if (cs_fall) begin
                        state_next = LEAD;
                        count_next = '0;
                    end else if (!cs_p1) begin
                        state_next = WAIT_CS;
                    end
                end
            end
            LEAD: begin
                if (cs_rise) begin
                    frame_err_next = 1'b1;
                    state_next     = IDLE;
                    count_next     = '0;
                end else if (cs_fall) begin
                    frame_err_next = 1'b1;
                    count_next     = '0;
                end else if (count >= CNT_LEAD) begin
                    state_next = SHIFT;
                    count_next = '0;
                end else if (sclk_fall) begin
                    count_next = count + 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    frame_err_next = 1'b1;
                    state_next     = IDLE;
                    count_next     = '0;
                end else if (cs_fall) begin
                    frame_err_next = 1'b1;
                    state_next     = LEAD;
                    count_next     = '0;
                end else if (sclk_fall) begin
                    shift_en = 1'b1;
                    if (count == CNT_LAST) begin
                        load       = 1'b1;
                        state_next = WAIT_CS;
                        count_next = CNT_FULL;
                    end else if (count < CNT_FULL) begin
                        count_next = count + 1'b1;
                    end
                end
            end
            WAIT_CS: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    count_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Shift register holds only partial-frame data; every bit is rewritten before use.
    always_ff @(posedge clk) begin
        if (shift_en)
            shreg[count] <= mosi_p1;
    end

    assign word = {mosi_p1, shreg[DATA_W-2:0]};

    // Output stage: word hand-off, overrun and frame-error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= frame_err_next;
            overrun   <= load && dout_valid && !dout_ready;
            if (load) begin
                dout       <= word;
                dout_valid <= 1'b1;
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

    assign busy = (state == LEAD) || (state == SHIFT);

endmodule
